// File: rtl/serial_adder_if.sv
// Bus interface for serial_adder: request/operand signals from the master,
// status/result signals back from the adder (slave).
// Optional SERIAL_ADDER_OVF_EN adds the signed-overflow flag ovf_out.
interface serial_adder_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic             cin_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum_out;
  logic             cout_out;
`ifdef SERIAL_ADDER_OVF_EN
  logic             ovf_out;

  modport master (
    output start, a_in, b_in, cin_in,
    input  busy, done, sum_out, cout_out, ovf_out
  );
  modport slave (
    input  start, a_in, b_in, cin_in,
    output busy, done, sum_out, cout_out, ovf_out
  );
`else
  modport master (
    output start, a_in, b_in, cin_in,
    input  busy, done, sum_out, cout_out
  );
  modport slave (
    input  start, a_in, b_in, cin_in,
    output busy, done, sum_out, cout_out
  );
`endif
endinterface

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder built around a single 1-bit full_adder cell.
// One operand bit pair is consumed per clock (LSB first); the result is
// published together with the final carry on the edge that enters DONE.
// Optional feature: define SERIAL_ADDER_OVF_EN to add the signed-overflow
// output ovf_out (carry into MSB XOR carry out of MSB).
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic          clk,
  input  logic          rst,
  serial_adder_if.slave bus
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  // Holds the WIDTH-1 low result bits; the MSB comes straight from the
  // adder on the last RUN cycle.
  logic [WIDTH-2:0] res_q, res_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
`ifdef SERIAL_ADDER_OVF_EN
  logic             ovf_q, ovf_d;
`endif

  logic             fa_sum;
  logic             fa_cout;
  logic [WIDTH-1:0] res_cat;
  logic             last_bit;

  full_adder u_fa (
    .a_i    (a_q[0]),
    .b_i    (b_q[0]),
    .cin_i  (carry_q),
    .sum_o  (fa_sum),
    .cout_o (fa_cout)
  );

  assign res_cat  = {fa_sum, res_q};
  assign last_bit = (cnt_q == LAST_BIT);

  // Next-state logic: operand load, per-bit shift/accumulate, result publish.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
    ovf_d   = ovf_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          a_d     = bus.a_in;
          b_d     = bus.b_in;
          carry_d = bus.cin_in;
          cnt_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        res_d   = res_cat[WIDTH-1:1];
        carry_d = fa_cout;
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        if (last_bit) begin
          // Counter parks on the last index instead of wrapping.
          sum_d   = res_cat;
          cout_d  = fa_cout;
`ifdef SERIAL_ADDER_OVF_EN
          ovf_d   = carry_q ^ fa_cout;
`endif
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign bus.busy     = (state_q != S_IDLE);
  assign bus.done     = (state_q == S_DONE);
  assign bus.sum_out  = sum_q;
  assign bus.cout_out = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
  assign bus.ovf_out  = ovf_q;
`endif

endmodule

// 1-bit full adder cell driven by the serial datapath above.
module full_adder (
  input  logic a_i,
  input  logic b_i,
  input  logic cin_i,
  output logic sum_o,
  output logic cout_o
);
  assign sum_o  = a_i ^ b_i ^ cin_i;
  assign cout_o = (a_i & b_i) | (cin_i & (a_i ^ b_i));
endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder (WIDTH=8): a transaction-level model
// pushes expected results on each accepted start; a monitor pops and
// compares whenever done is presented.
module tb_serial_adder;

  localparam int W = 8;

  logic clk;
  logic rst;

  serial_adder_if #(.WIDTH(W)) bus ();

  serial_adder #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    int           due;
  } exp_t;

  exp_t         sbq[$];
  int           checks   = 0;
  int           failures = 0;
  int           cyc      = 0;
  int           busy_left = 0;
  bit           mon_en   = 1'b0;
  logic [W-1:0] hold_sum = '0;
  logic         hold_cout = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: an operation accepted while idle occupies the adder
  // for WIDTH+1 cycles; its result appears WIDTH cycles after acceptance.
  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      busy_left = 0;
      sbq.delete();
      hold_sum  = '0;
      hold_cout = 1'b0;
    end else if (busy_left == 0 && bus.start) begin
      exp_t e;
      logic [W:0] tot;
      tot    = {1'b0, bus.a_in} + {1'b0, bus.b_in} + (W+1)'(bus.cin_in);
      e.sum  = tot[W-1:0];
      e.cout = tot[W];
      e.ovf  = (bus.a_in[W-1] == bus.b_in[W-1]) && (tot[W-1] != bus.a_in[W-1]);
      e.due  = cyc + W;
      sbq.push_back(e);
      busy_left = W + 1;
    end else if (busy_left > 0) begin
      busy_left--;
    end
  end

  // Monitor: compares status every cycle and results whenever done is due.
  always @(negedge clk) begin
    if (mon_en) begin
      bit exp_done;
      exp_done = (sbq.size() > 0) && (sbq[0].due == cyc);
      chk("busy", 64'(bus.busy), 64'(busy_left > 0));
      chk("done", 64'(bus.done), 64'(exp_done));
      if (exp_done) begin
        exp_t e;
        e = sbq.pop_front();
        chk("sum_out", 64'(bus.sum_out), 64'(e.sum));
        chk("cout_out", 64'(bus.cout_out), 64'(e.cout));
`ifdef SERIAL_ADDER_OVF_EN
        chk("ovf_out", 64'(bus.ovf_out), 64'(e.ovf));
`endif
        hold_sum  = e.sum;
        hold_cout = e.cout;
        $display("txn cycle=%0d sum=0x%0h cout=%0b", cyc, bus.sum_out, bus.cout_out);
      end
      chk("sum_hold", 64'(bus.sum_out), 64'(hold_sum));
      chk("cout_hold", 64'(bus.cout_out), 64'(hold_cout));
    end
  end

  // One operation: start for one cycle, then scramble operands while busy.
  task automatic op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
    bus.start  = 1'b1;
    bus.a_in   = a;
    bus.b_in   = b;
    bus.cin_in = c;
    @(negedge clk);
    bus.start  = 1'b0;
    bus.a_in   = W'($urandom);
    bus.b_in   = W'($urandom);
    bus.cin_in = 1'($urandom);
    repeat (W + 1) @(negedge clk);
  endtask

  initial begin
    rst        = 1'b1;
    bus.start  = 1'b0;
    bus.a_in   = '0;
    bus.b_in   = '0;
    bus.cin_in = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_done", 64'(bus.done), 64'd0);
    chk("rst_sum", 64'(bus.sum_out), 64'd0);
    chk("rst_cout", 64'(bus.cout_out), 64'd0);
    rst    = 1'b0;
    mon_en = 1'b1;

    // Directed cases, including carry/overflow boundaries.
    op(8'h5A, 8'h3C, 1'b0);
    op(8'hFF, 8'h01, 1'b0);
    op(8'hFF, 8'h00, 1'b1);
    op(8'h7F, 8'h01, 1'b0);
    op(8'h00, 8'h00, 1'b0);
    op(8'hFF, 8'hFF, 1'b1);

    // start held high with operands changing every cycle.
    for (int i = 0; i < 40; i++) begin
      bus.start  = 1'b1;
      bus.a_in   = W'($urandom);
      bus.b_in   = W'($urandom);
      bus.cin_in = 1'($urandom);
      @(negedge clk);
    end
    bus.start = 1'b0;
    repeat (W + 3) @(negedge clk);

    // Reset partway through RUN aborts without a done.
    bus.start  = 1'b1;
    bus.a_in   = 8'hA5;
    bus.b_in   = 8'h5A;
    bus.cin_in = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", 64'(bus.busy), 64'd0);
    chk("abort_done", 64'(bus.done), 64'd0);
    chk("abort_sum", 64'(bus.sum_out), 64'd0);
    repeat (W + 3) @(negedge clk);
    op(8'h12, 8'h34, 1'b1);

    // Randomized operands.
    for (int i = 0; i < 1000; i++) begin
      op(W'($urandom), W'($urandom), 1'($urandom));
    end

    repeat (W + 3) @(negedge clk);
    chk("sb_empty", 64'(sbq.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
